pulse_arbiter: RTL and testbench

Round-robin scheduler that shares one timed output pulse (lamp/enable `X`) among `N_REQ` button requesters. Each requester's press is latched as a pending request. Requests are then served one at a time: a `PULSE_LEN`-cycle on-window followed by a `GAP_LEN`-cycle off-window. The block sits between debounced button inputs and the single shared output resource, and reports which requester owns the current pulse.

---
 rtl/pulse_arbiter.sv | 159 +++++++++++++++
 tb/tb_pulse_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_arbiter.sv
// Round-robin scheduler sharing one timed output pulse among N_REQ requesters.
// Requests latch into Pending and are served as PULSE_LEN on / GAP_LEN off windows.
module pulse_arbiter #(
  parameter int N_REQ     = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [N_REQ-1:0]         B,
  output logic                     X,
  output logic [N_REQ-1:0]         Grant,
  output logic [$clog2(N_REQ)-1:0] GrantId,
  output logic [N_REQ-1:0]         Pending,
  output logic                     Done,
  output logic [1:0]               State
);

  localparam int IW   = $clog2(N_REQ);
  localparam int CMAX = (PULSE_LEN > GAP_LEN) ? ((PULSE_LEN > 2) ? PULSE_LEN : 2)
                                              : ((GAP_LEN > 2) ? GAP_LEN : 2);
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [IW-1:0]      ptr_reg, ptr_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [IW-1:0]      id_reg, id_next;
  logic [N_REQ-1:0]   pend_reg, pend_next;
  logic               x_reg, x_next;
  logic               done_reg, done_next;

  logic [N_REQ-1:0]   eff;
  logic [2*N_REQ-1:0] rot2;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_first;
  logic [IW-1:0]      off_acc [N_REQ+1];
  logic [IW:0]        win_sum;
  logic [IW-1:0]      win;
  logic [IW:0]        win_p1;
  logic [N_REQ-1:0]   win_oh;
  logic               found;
  logic               arb;

  // Rotate the request vector so bit 0 is the requester at ptr, then take the lowest set bit.
  assign eff       = pend_reg | B;
  assign rot2      = {eff, eff} >> ptr_reg;
  assign rot       = rot2[N_REQ-1:0];
  assign rot_first = rot & ~(rot - N_REQ'(1));
  assign found     = |eff;
  assign off_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_enc
      assign off_acc[gi+1] = off_acc[gi] | (rot_first[gi] ? IW'(gi) : '0);
      assign win_oh[gi]    = (win == IW'(gi));
    end
  endgenerate

  assign win_sum = {1'b0, ptr_reg} + {1'b0, off_acc[N_REQ]};
  assign win     = (win_sum >= (IW+1)'(N_REQ)) ? IW'(win_sum - (IW+1)'(N_REQ)) : win_sum[IW-1:0];
  assign win_p1  = {1'b0, win} + (IW+1)'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    id_next    = id_reg;
    x_next     = x_reg;
    arb        = 1'b0;
    done_next  = (state_reg == ON) && (cnt_reg == '0);

    case (state_reg)
      IDLE: arb = 1'b1;
      ON: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (GAP_LEN > 0) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
          x_next     = 1'b0;
          grant_next = '0;
        end else begin
          arb = 1'b1;
        end
      end
      GAP: begin
        x_next     = 1'b0;
        grant_next = '0;
        if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
        else               arb      = 1'b1;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        x_next     = 1'b0;
        grant_next = '0;
      end
    endcase

    if (arb) begin
      if (found) begin
        state_next = ON;
        cnt_next   = PULSE_LOAD;
        x_next     = 1'b1;
        grant_next = win_oh;
        id_next    = win;
        ptr_next   = (win_p1 == (IW+1)'(N_REQ)) ? '0 : win_p1[IW-1:0];
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
        x_next     = 1'b0;
        grant_next = '0;
      end
    end

    // The winner's own request in its grant cycle is absorbed.
    pend_next = eff & ~((arb && found) ? win_oh : '0);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
      id_reg    <= '0;
      pend_reg  <= '0;
      x_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      id_reg    <= id_next;
      pend_reg  <= pend_next;
      x_reg     <= x_next;
      done_reg  <= done_next;
    end
  end

  assign X       = x_reg;
  assign Grant   = grant_reg;
  assign GrantId = id_reg;
  assign Pending = pend_reg;
  assign Done    = done_reg;
  assign State   = state_reg;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Bench for pulse_arbiter: two instances (gap 1 and gap 0) checked each cycle against
// a phase/age reference model, plus directed checks of the documented scenarios.
module tb_pulse_arbiter;

  localparam int N  = 4;
  localparam int PL = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] B   = 4'h0;

  logic       xa, xb, done_a, done_b;
  logic [3:0] grant_a, grant_b, pend_a, pend_b;
  logic [1:0] id_a, id_b, state_a, state_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase (0 idle, 1 on, 2 gap), cycles spent in phase, owner, pointer.
  int         m_state [2];
  int         m_age   [2];
  int         m_owner [2];
  int         m_ptr   [2];
  int         m_id    [2];
  logic [3:0] m_pend  [2];
  logic       m_done  [2];

  pulse_arbiter #(.N_REQ(N), .PULSE_LEN(PL), .GAP_LEN(1)) u_dut_gap1 (
    .Clk(Clk), .Rst(Rst), .B(B), .X(xa), .Grant(grant_a), .GrantId(id_a),
    .Pending(pend_a), .Done(done_a), .State(state_a)
  );

  pulse_arbiter #(.N_REQ(N), .PULSE_LEN(PL), .GAP_LEN(0)) u_dut_gap0 (
    .Clk(Clk), .Rst(Rst), .B(B), .X(xb), .Grant(grant_b), .GrantId(id_b),
    .Pending(pend_b), .Done(done_b), .State(state_b)
  );

  always #5 Clk = ~Clk;

  function automatic int gap_of(input int m);
    return (m == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_state[m] = 0; m_age[m] = 0; m_owner[m] = 0; m_ptr[m] = 0; m_id[m] = 0;
      m_pend[m] = 4'h0; m_done[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] b);
    logic [3:0] eff;
    bit wend, gend, arb;
    int w, idx;
    eff  = m_pend[m] | b;
    wend = (m_state[m] == 1) && (m_age[m] == PL - 1);
    gend = (m_state[m] == 2) && (m_age[m] == gap_of(m) - 1);
    arb  = (m_state[m] == 0) || (wend && gap_of(m) == 0) || gend;
    m_done[m] = wend;
    m_pend[m] = eff;
    if (arb) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr[m] + k) % N;
        if (w < 0 && ((eff >> idx) & 4'd1) != 4'd0) w = idx;
      end
      m_age[m] = 0;
      if (w >= 0) begin
        m_state[m] = 1; m_owner[m] = w; m_id[m] = w; m_ptr[m] = (w + 1) % N;
        m_pend[m]  = m_pend[m] & ~(4'b0001 << w);
      end else begin
        m_state[m] = 0;
      end
    end else if (wend) begin
      m_state[m] = 2; m_age[m] = 0;
    end else begin
      m_age[m]++;
    end
  endtask

  task automatic check_dut(input int m, input logic x, input logic [3:0] g, input logic [1:0] id,
                           input logic [3:0] p, input logic d, input logic [1:0] s);
    logic [3:0] eg;
    eg = (m_state[m] == 1) ? 4'(1 << m_owner[m]) : 4'h0;
    chk($sformatf("d%0d_X", m),       32'(x),  32'(m_state[m] == 1));
    chk($sformatf("d%0d_Grant", m),   32'(g),  32'(eg));
    chk($sformatf("d%0d_GrantId", m), 32'(id), 32'(m_id[m]));
    chk($sformatf("d%0d_Pending", m), 32'(p),  32'(m_pend[m]));
    chk($sformatf("d%0d_Done", m),    32'(d),  32'(m_done[m]));
    chk($sformatf("d%0d_State", m),   32'(s),  32'(m_state[m]));
  endtask

  task automatic check_all();
    check_dut(0, xa, grant_a, id_a, pend_a, done_a, state_a);
    check_dut(1, xb, grant_b, id_b, pend_b, done_b, state_b);
  endtask

  task automatic cycle(input logic [3:0] b, input logic r);
    @(negedge Clk);
    B   = b;
    Rst = r;
    @(posedge Clk);
    if (r) begin
      model_step(0, b);
      model_step(1, b);
    end else begin
      model_reset();
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [10:0] xs;
    logic        prev_x;
    int          n, xcnt, dcnt;
    logic [3:0]  eg;

    model_reset();

    // Reset held with all buttons pressed
    for (int i = 0; i < 3; i++) cycle(4'hF, 1'b0);

    // Single request
    cycle(4'h0, 1'b1);
    cycle(4'h0, 1'b1);
    cycle(4'b0100, 1'b1);
    chk("single_grant", 32'(grant_a), 32'h4);
    chk("single_id",    32'(id_a),    32'd2);
    cycle(4'h0, 1'b1);
    cycle(4'h0, 1'b1);
    chk("single_x_last", 32'(xa), 32'd1);
    cycle(4'h0, 1'b1);
    chk("single_done",  32'(done_a),  32'd1);
    chk("single_gap",   32'(state_a), 32'd2);
    cycle(4'h0, 1'b1);
    chk("single_idle",  32'(state_a), 32'd0);

    // Simultaneous requests from a fresh pointer
    cycle(4'h0, 1'b0);
    cycle(4'h0, 1'b1);
    xs = '0;
    cycle(4'b1011, 1'b1);
    xs = {xs[9:0], xa};
    for (int i = 0; i < 10; i++) begin
      cycle(4'h0, 1'b1);
      xs = {xs[9:0], xa};
    end
    chk("simul_x_pattern", 32'(xs), 32'b11101110111);
    chk("simul_pend_end",  32'(pend_a), 32'h0);

    // Fairness with two requesters held high
    cycle(4'h0, 1'b0);
    prev_x = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(4'b0011, 1'b1);
      if (xa && !prev_x) begin
        chk("fair_id", 32'(id_a), 32'(n % 2));
        n++;
      end
      prev_x = xa;
    end
    chk("fair_grants", 32'(n), 32'd8);

    // Zero gap: back-to-back grants on the gap-0 instance
    cycle(4'h0, 1'b0);
    cycle(4'h0, 1'b1);
    xcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle((i == 0) ? 4'b0110 : 4'b0000, 1'b1);
      eg = (i < 3) ? 4'b0010 : ((i < 6) ? 4'b0100 : 4'b0000);
      chk("zgap_grant", 32'(grant_b), 32'(eg));
      if (xb) xcnt++;
      if (done_b) dcnt++;
    end
    chk("zgap_x_len", 32'(xcnt), 32'd6);
    chk("zgap_done",  32'(dcnt), 32'd2);

    // Asynchronous reset in the middle of a window
    cycle(4'h0, 1'b0);
    cycle(4'b1010, 1'b1);
    cycle(4'h0, 1'b1);
    chk("midrst_pend_before", 32'(pend_a), 32'h8);
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_x",     32'(xa),      32'd0);
    chk("midrst_pend",  32'(pend_a),  32'h0);
    chk("midrst_state", 32'(state_a), 32'd0);
    check_all();
    cycle(4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'h0, 1'b1);
      chk("midrst_stay_idle", 32'(state_a), 32'd0);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            ($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
